// File: rtl/ram_upload_server_if.sv
// ram_upload_server_if: ioctl upload handshake and game RAM read port seen by the upload responder.
// The master side is the HPS/RAM environment; the slave side is the responder.
interface ram_upload_server_if #(
  parameter int ADDR_W = 16
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_upload_req;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_intent_read;
  logic [7:0]        data_from_ram;
  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, data_from_ram,
    input  ioctl_din, ioctl_upload_req, ram_address, ram_intent_read
  );
  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, data_from_ram,
    output ioctl_din, ioctl_upload_req, ram_address, ram_intent_read
  );
endinterface

// File: rtl/ram_upload_server.sv
// ram_upload_server: serves a window of game work RAM back to the HPS over the ioctl upload path,
// pausing the CPU while bytes are fetched through the RAM intent/read port.
module ram_upload_server #(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = 16'h6000,
  parameter int                LEN    = 101,
  parameter int                IDX    = 6,
  parameter int                RD_LAT = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 trigger,
  input  logic                 paused,
  output logic                 pause_cpu,
  output logic                 busy,
  ram_upload_server_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, REQ, PAUSE, READY, FETCH} state_t;
  state_t     state;
  logic [1:0] rst_sync;
  logic       rst_n_s;
  logic       trig_q;
  logic       act_q;
  logic       active;
  logic [2:0] cnt;
  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n_s = rst_sync[1];
  assign active = bus.ioctl_upload && bus.ioctl_index == 8'(IDX);
  assign busy = state != IDLE;
  assign pause_cpu = state == PAUSE || state == READY || state == FETCH;
  assign bus.ioctl_upload_req = state == REQ;
  always_ff @(posedge clk_sys or negedge rst_n_s)
    if (!rst_n_s) begin
      state               <= IDLE;
      trig_q              <= 1'b0;
      act_q               <= 1'b0;
      cnt                 <= '0;
      bus.ioctl_din       <= '0;
      bus.ram_address     <= BASE;
      bus.ram_intent_read <= 1'b0;
    end else begin
      trig_q <= trigger;
      act_q  <= active;
      case (state)
        IDLE:  if (active && !act_q) state <= PAUSE;
               else if (trigger && !trig_q) state <= REQ;
        REQ:   if (active && !act_q) state <= PAUSE;
        PAUSE: if (!active) state <= IDLE;
               else if (paused) state <= READY;
        READY: if (!active) state <= IDLE;
               else if (bus.ioctl_rd) begin
                 // Range check uses all address bits; only the low byte reaches the RAM.
                 if (bus.ioctl_addr < 25'(LEN)) begin
                   bus.ram_address     <= BASE + ADDR_W'(bus.ioctl_addr[7:0]);
                   bus.ram_intent_read <= 1'b1;
                   cnt                 <= 3'(RD_LAT);
                   state               <= FETCH;
                 end else bus.ioctl_din <= 8'h00;
               end
        FETCH: if (!active) begin
                 bus.ram_intent_read <= 1'b0;
                 state               <= IDLE;
               end else if (cnt == 3'd0) begin
                 bus.ioctl_din       <= bus.data_from_ram;
                 bus.ram_intent_read <= 1'b0;
                 state               <= READY;
               end else cnt <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ram_upload_server.sv
// tb_ram_upload_server: randomized scenarios for the upload responder, checked against a
// byte-window model of the game RAM and the expected ioctl_din history.
module tb_ram_upload_server;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h6000;
  localparam int          LEN    = 101;
  localparam int          IDX    = 6;
  localparam int          RD_LAT = 2;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic trigger = 1'b0;
  logic paused  = 1'b0;
  logic pause_cpu, busy;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  logic       intent_q = 1'b0;
  logic [7:0] din_ref = 8'h00;
  logic [7:0] mem [65536];
  logic [7:0] pipe [RD_LAT];
  ram_upload_server_if #(.ADDR_W(ADDR_W)) bus();
  ram_upload_server #(.ADDR_W(ADDR_W), .BASE(BASE), .LEN(LEN), .IDX(IDX), .RD_LAT(RD_LAT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .trigger(trigger), .paused(paused),
    .pause_cpu(pause_cpu), .busy(busy), .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  // RAM with RD_LAT clocks from address to data.
  always @(posedge clk_sys) begin
    pipe[0] <= mem[bus.ram_address];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.data_from_ram = pipe[RD_LAT-1];
  always @(posedge clk_sys) begin
    intent_q <= bus.ram_intent_read;
    if (bus.ram_intent_read && !intent_q) pulses <= pulses + 1;
  end
  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    return a < 25'(LEN) ? mem[BASE + 16'(a[7:0])] : 8'h00;
  endfunction
  task automatic step();
    @(negedge clk_sys);
  endtask
  task automatic enter_ready();
    bus.ioctl_upload = 1'b1;
    bus.ioctl_index = 8'(IDX);
    paused = 1'b0;
    step();
    paused = 1'b1;
    step();
  endtask
  task automatic issue_rd(input logic [24:0] a);
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = a;
    step();
    bus.ioctl_rd = 1'b0;
  endtask
  task automatic test_reset();
    logic [28:0] rv;
    rv = {8'h00, 1'b0, 1'b0, BASE, 1'b0, 1'b0};
    n_cmp++;
    if ({bus.ioctl_din, bus.ioctl_upload_req, pause_cpu, bus.ram_address, bus.ram_intent_read, busy} !== rv) begin
      n_bad++; $display("FAIL reset_power_on got=%h exp=%h", {bus.ioctl_din, bus.ioctl_upload_req, pause_cpu, bus.ram_address, bus.ram_intent_read, busy}, rv);
    end
    enter_ready();
    issue_rd(25'($urandom_range(0, LEN-1)));
    step();
    n_cmp++;
    if ({bus.ram_intent_read, busy} !== 2'b11) begin
      n_bad++; $display("FAIL reset_pre_fetch got=%b exp=11", {bus.ram_intent_read, busy});
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ioctl_din, bus.ioctl_upload_req, pause_cpu, bus.ram_address, bus.ram_intent_read, busy} !== rv) begin
      n_bad++; $display("FAIL reset_mid_fetch got=%h exp=%h", {bus.ioctl_din, bus.ioctl_upload_req, pause_cpu, bus.ram_address, bus.ram_intent_read, busy}, rv);
    end
    bus.ioctl_upload = 1'b0;
    paused = 1'b0;
    din_ref = 8'h00;
    step();
    reset_n = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({bus.ioctl_din, bus.ioctl_upload_req, pause_cpu, bus.ram_address, bus.ram_intent_read, busy} !== rv) begin
      n_bad++; $display("FAIL reset_release got=%h exp=%h", {bus.ioctl_din, bus.ioctl_upload_req, pause_cpu, bus.ram_address, bus.ram_intent_read, busy}, rv);
    end
  endtask
  task automatic test_trigger_request();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    n_cmp++;
    if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b101) begin
      n_bad++; $display("FAIL trig_req got=%b exp=101", {bus.ioctl_upload_req, pause_cpu, busy});
    end
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 3) == 0) trigger = ~trigger;
      step();
      n_cmp++;
      if ({bus.ioctl_upload_req, pause_cpu} !== 2'b10) begin
        n_bad++; $display("FAIL trig_hold cyc=%0d got=%b exp=10", k, {bus.ioctl_upload_req, pause_cpu});
      end
    end
    trigger = 1'b0;
    bus.ioctl_index = 8'(IDX);
    bus.ioctl_upload = 1'b1;
    step();
    n_cmp++;
    if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b011) begin
      n_bad++; $display("FAIL trig_accept got=%b exp=011", {bus.ioctl_upload_req, pause_cpu, busy});
    end
    step();
    n_cmp++;
    if ({bus.ioctl_upload_req, pause_cpu, bus.ram_intent_read} !== 3'b010) begin
      n_bad++; $display("FAIL trig_pause_wait got=%b exp=010", {bus.ioctl_upload_req, pause_cpu, bus.ram_intent_read});
    end
    bus.ioctl_upload = 1'b0;
    step();
    n_cmp++;
    if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b000) begin
      n_bad++; $display("FAIL trig_drop got=%b exp=000", {bus.ioctl_upload_req, pause_cpu, busy});
    end
  endtask
  task automatic test_single_read();
    mem[BASE] = 8'hA5;
    enter_ready();
    issue_rd(25'd0);
    for (int k = 0; k <= RD_LAT; k++) begin
      n_cmp++;
      if ({bus.ram_address, bus.ram_intent_read, bus.ioctl_din} !== {BASE, 1'b1, din_ref}) begin
        n_bad++; $display("FAIL single_fetch k=%0d got=%h exp=%h", k, {bus.ram_address, bus.ram_intent_read, bus.ioctl_din}, {BASE, 1'b1, din_ref});
      end
      step();
    end
    din_ref = 8'hA5;
    n_cmp++;
    if ({bus.ioctl_din, bus.ram_intent_read} !== {din_ref, 1'b0}) begin
      n_bad++; $display("FAIL single_din got=%h exp=%h", {bus.ioctl_din, bus.ram_intent_read}, {din_ref, 1'b0});
    end
  endtask
  task automatic test_sequential();
    int p;
    logic [24:0] oor [4];
    p = pulses;
    for (int a = 0; a < LEN; a++) begin
      repeat ($urandom_range(0, 2)) step();
      issue_rd(25'(a));
      repeat (RD_LAT) step();
      n_cmp++;
      if (bus.ram_intent_read !== 1'b1) begin
        n_bad++; $display("FAIL seq_intent addr=%0d got=%b exp=1", a, bus.ram_intent_read);
      end
      step();
      din_ref = exp_byte(25'(a));
      n_cmp++;
      if (bus.ioctl_din !== din_ref) begin
        n_bad++; $display("FAIL seq_din addr=%0d got=%h exp=%h", a, bus.ioctl_din, din_ref);
      end
    end
    n_cmp++;
    if (pulses - p !== LEN) begin
      n_bad++; $display("FAIL seq_pulses got=%0d exp=%0d", pulses - p, LEN);
    end
    oor[0] = 25'd101;
    oor[1] = 25'h100000;
    oor[2] = 25'($urandom_range(LEN, 255));
    oor[3] = 25'h100 | 25'($urandom_range(0, LEN-1));
    foreach (oor[i]) begin
      issue_rd(25'($urandom_range(0, LEN-1)));
      repeat (RD_LAT + 1) step();
      p = pulses;
      issue_rd(oor[i]);
      din_ref = exp_byte(oor[i]);
      n_cmp++;
      if (bus.ioctl_din !== din_ref) begin
        n_bad++; $display("FAIL oor_din addr=%h got=%h exp=%h", oor[i], bus.ioctl_din, din_ref);
      end
      repeat (3) step();
      n_cmp++;
      if ({bus.ioctl_din, bus.ram_intent_read} !== {din_ref, 1'b0} || pulses != p) begin
        n_bad++; $display("FAIL oor_noram addr=%h got=%h/%0d exp=%h/%0d", oor[i], {bus.ioctl_din, bus.ram_intent_read}, pulses, {din_ref, 1'b0}, p);
      end
    end
  endtask
  task automatic test_back_to_back();
    int p, a, b;
    a = $urandom_range(0, LEN-1);
    b = (a + 1) % LEN;
    mem[BASE + 16'(b)] = mem[BASE + 16'(a)] ^ 8'hFF;
    p = pulses;
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 25'(a);
    step();
    bus.ioctl_addr = 25'(b);
    step();
    bus.ioctl_rd = 1'b0;
    step();
    n_cmp++;
    if (bus.ram_intent_read !== 1'b1) begin
      n_bad++; $display("FAIL proto_intent got=%b exp=1", bus.ram_intent_read);
    end
    step();
    din_ref = exp_byte(25'(a));
    repeat (4) step();
    n_cmp++;
    if (bus.ioctl_din !== din_ref || pulses != p + 1) begin
      n_bad++; $display("FAIL proto_ignore got=%h/%0d exp=%h/%0d", bus.ioctl_din, pulses - p, din_ref, 1);
    end
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, LEN-1);
      issue_rd(25'(a));
      repeat (RD_LAT + 1) step();
      din_ref = exp_byte(25'(a));
      n_cmp++;
      if (bus.ioctl_din !== din_ref) begin
        n_bad++; $display("FAIL b2b_din addr=%0d got=%h exp=%h", a, bus.ioctl_din, din_ref);
      end
    end
  endtask
  task automatic test_abort();
    int a;
    a = $urandom_range(0, LEN-1);
    mem[BASE + 16'(a)] = ~din_ref;
    issue_rd(25'(a));
    step();
    bus.ioctl_upload = 1'b0;
    step();
    n_cmp++;
    if ({busy, pause_cpu, bus.ram_intent_read, bus.ioctl_din} !== {3'b000, din_ref}) begin
      n_bad++; $display("FAIL abort got=%h exp=%h", {busy, pause_cpu, bus.ram_intent_read, bus.ioctl_din}, {3'b000, din_ref});
    end
    repeat (4) step();
    n_cmp++;
    if ({busy, bus.ioctl_din} !== {1'b0, din_ref}) begin
      n_bad++; $display("FAIL abort_hold got=%h exp=%h", {busy, bus.ioctl_din}, {1'b0, din_ref});
    end
  endtask
  task automatic test_wrong_index();
    int p;
    p = pulses;
    paused = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.ioctl_index = (k < 4) ? 8'd5 : 8'(IDX + $urandom_range(1, 200));
      bus.ioctl_upload = (k != 4);
      bus.ioctl_rd = $urandom_range(0, 1) == 1;
      bus.ioctl_addr = 25'($urandom_range(0, LEN-1));
      step();
      bus.ioctl_rd = 1'b0;
      n_cmp++;
      if ({busy, pause_cpu, bus.ram_intent_read, bus.ioctl_din} !== {3'b000, din_ref}) begin
        n_bad++; $display("FAIL wrong_idx k=%0d got=%h exp=%h", k, {busy, pause_cpu, bus.ram_intent_read, bus.ioctl_din}, {3'b000, din_ref});
      end
    end
    n_cmp++;
    if (pulses != p) begin
      n_bad++; $display("FAIL wrong_idx_pulses got=%0d exp=%0d", pulses, p);
    end
    bus.ioctl_upload = 1'b0;
    step();
  endtask
  task automatic test_trigger_busy();
    enter_ready();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    n_cmp++;
    if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b011) begin
      n_bad++; $display("FAIL busy_trig got=%b exp=011", {bus.ioctl_upload_req, pause_cpu, busy});
    end
    bus.ioctl_upload = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b000) begin
        n_bad++; $display("FAIL busy_no_queue k=%0d got=%b exp=000", k, {bus.ioctl_upload_req, pause_cpu, busy});
      end
    end
    paused = 1'b0;
    trigger = 1'b1;
    bus.ioctl_index = 8'(IDX);
    bus.ioctl_upload = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b011) begin
        n_bad++; $display("FAIL coincident k=%0d got=%b exp=011", k, {bus.ioctl_upload_req, pause_cpu, busy});
      end
      step();
    end
    bus.ioctl_upload = 1'b0;
    step();
    n_cmp++;
    if ({bus.ioctl_upload_req, pause_cpu, busy} !== 3'b000) begin
      n_bad++; $display("FAIL coincident_end got=%b exp=000", {bus.ioctl_upload_req, pause_cpu, busy});
    end
  endtask
  initial begin
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'h00;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(1, 255));
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    test_reset();
    test_trigger_request();
    test_single_read();
    test_sequential();
    test_back_to_back();
    test_abort();
    test_wrong_index();
    test_trigger_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
